ula_multiciclo: RTL and testbench

Parametrised, registered successor to the single-cycle ULA. It adds a valid/ready handshake on both sides, signed overflow and signed/unsigned compare, and iterative multi-cycle unsigned multiply and divide. It sits in the datapath's execute stage; the control unit issues one operation at a time and consumes the result under backpressure. Results and flags are registered and held until accepted.

---
 rtl/ula_multiciclo.sv | 155 +++++++++++++++
 tb/tb_ula_multiciclo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - registered multi-cycle ALU with valid/ready handshake, iterative MULU/DIVU
module ula_multiciclo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] entrada_01,
    input  logic [W-1:0] entrada_02,
    input  logic [3:0]   ULA_control,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] ULA_result,
    output logic [W-1:0] ULA_result_hi,
    output logic         Zero,
    output logic         Overflow,
    output logic         Div_zero,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int CW = $clog2(W) + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          is_div_q;
    logic [W-1:0]  opnd_q;      // multiplicand (MULU) or divisor (DIVU)
    logic [W-1:0]  hi_q;        // product high word / partial remainder
    logic [W-1:0]  lo_q;        // multiplier being shifted out / dividend becoming quotient

    logic          accept, is_iter, last;
    logic [W-1:0]  sum, diff, res_s, hi_s;
    logic          ovf_s, dz_s;
    logic [W:0]    mul_sum, div_sh;
    logic          div_ge;
    logic [W-1:0]  iter_hi, iter_lo;

    assign accept   = in_valid && (state == S_IDLE);
    assign is_iter  = (ULA_control == OP_MULU) ||
                      ((ULA_control == OP_DIVU) && (entrada_02 != '0));
    assign last     = (cnt == CW'(W - 1));
    assign in_ready = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_comb begin
        res_s = '0;
        hi_s  = '0;
        ovf_s = 1'b0;
        dz_s  = 1'b0;
        sum   = entrada_01 + entrada_02;
        diff  = entrada_01 - entrada_02;
        case (ULA_control)
            OP_AND:  res_s = entrada_01 & entrada_02;
            OP_OR:   res_s = entrada_01 | entrada_02;
            OP_NOR:  res_s = ~(entrada_01 | entrada_02);
            OP_ADD: begin
                res_s = sum;
                ovf_s = (entrada_01[W-1] == entrada_02[W-1]) && (sum[W-1] != entrada_01[W-1]);
            end
            OP_SUB: begin
                res_s = diff;
                ovf_s = (entrada_01[W-1] != entrada_02[W-1]) && (diff[W-1] != entrada_01[W-1]);
            end
            OP_SLT:  res_s = {{(W-1){1'b0}}, ($signed(entrada_01) < $signed(entrada_02))};
            OP_SLTU: res_s = {{(W-1){1'b0}}, (entrada_01 < entrada_02)};
            OP_DIVU: begin
                // only reached here with a zero divisor; nonzero divisors iterate
                res_s = '1;
                hi_s  = entrada_01;
                dz_s  = 1'b1;
            end
            default: ;
        endcase
    end

    // One shift-add or one restoring-divide step per CALC cycle
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh  = {hi_q, lo_q[W-1]};
        div_ge  = (div_sh >= {1'b0, opnd_q});
        if (is_div_q) begin
            iter_hi = div_ge ? (div_sh[W-1:0] - opnd_q) : div_sh[W-1:0];
            iter_lo = {lo_q[W-2:0], div_ge};
        end else begin
            iter_hi = mul_sum[W:1];
            iter_lo = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = is_iter ? S_CALC : S_DONE;
            S_CALC: if (last) state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            is_div_q      <= 1'b0;
            opnd_q        <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            ULA_result    <= '0;
            ULA_result_hi <= '0;
            Zero          <= 1'b0;
            Overflow      <= 1'b0;
            Div_zero      <= 1'b0;
        end else if (state == S_IDLE && accept) begin
            cnt      <= '0;
            is_div_q <= (ULA_control == OP_DIVU);
            opnd_q   <= (ULA_control == OP_DIVU) ? entrada_02 : entrada_01;
            lo_q     <= (ULA_control == OP_DIVU) ? entrada_01 : entrada_02;
            hi_q     <= '0;
            if (!is_iter) begin
                ULA_result    <= res_s;
                ULA_result_hi <= hi_s;
                Zero          <= (res_s == '0);
                Overflow      <= ovf_s;
                Div_zero      <= dz_s;
            end
        end else if (state == S_CALC) begin
            cnt  <= cnt + CW'(1);
            hi_q <= iter_hi;
            lo_q <= iter_lo;
            if (last) begin
                ULA_result    <= iter_lo;
                ULA_result_hi <= iter_hi;
                Zero          <= (iter_lo == '0);
                Overflow      <= 1'b0;
                Div_zero      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb/tb_ula_multiciclo.sv - self-checking bench for ula_multiciclo (vectors, random vs model, corner sequences)
module tb_ula_multiciclo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] entrada_01 = '0, entrada_02 = '0;
    logic [3:0]  ULA_control = '0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, Zero, Overflow, Div_zero, out_valid;
    logic [31:0] ULA_result, ULA_result_hi;

    int checks = 0;
    int errors = 0;

    ula_multiciclo #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .entrada_01(entrada_01), .entrada_02(entrada_02),
        .ULA_control(ULA_control), .in_valid(in_valid), .in_ready(in_ready),
        .ULA_result(ULA_result), .ULA_result_hi(ULA_result_hi),
        .Zero(Zero), .Overflow(Overflow), .Div_zero(Div_zero),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        ov;
        logic        dz;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.res = '0; e.hi = '0; e.ov = 1'b0; e.dz = 1'b0; e.lat = 1;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0100: e.res = ~(a | b);
            4'b0010: begin
                e.res = a + b; s = sa + sb;
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                e.res = a - b; s = sa - sb;
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'b0101: e.res = (a < b) ? 32'd1 : 32'd0;
            4'b1000: begin
                p = {32'b0, a} * {32'b0, b};
                e.res = p[31:0]; e.hi = p[63:32]; e.lat = 33;
            end
            4'b1010: begin
                if (b == 0) begin
                    e.res = 32'hFFFFFFFF; e.hi = a; e.dz = 1'b1;
                end else begin
                    e.res = a / b; e.hi = a % b; e.lat = 33;
                end
            end
            default: ;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output exp_t act, output logic busy_bad);
        busy_bad = 1'b0;
        @(negedge clk);
        chk("in_ready_before_accept", in_ready, 1);
        ULA_control = op; entrada_01 = a; entrada_02 = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        entrada_01 = $urandom; entrada_02 = $urandom; ULA_control = 4'($urandom);
        act.lat = 1;
        while (!out_valid && act.lat < 100) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk); #1;
            act.lat++;
        end
        act.res = ULA_result; act.hi = ULA_result_hi;
        act.z = Zero; act.ov = Overflow; act.dz = Div_zero;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("consume_out_valid", out_valid, 0);
        chk("consume_in_ready", in_ready, 1);
    endtask

    task automatic compare(input string tag, input exp_t act, input exp_t e, input logic busy_bad);
        chk({tag, "_result"}, act.res, e.res);
        chk({tag, "_hi"}, act.hi, e.hi);
        chk({tag, "_zero"}, act.z, e.z);
        chk({tag, "_overflow"}, act.ov, e.ov);
        chk({tag, "_div_zero"}, act.dz, e.dz);
        chk({tag, "_latency"}, act.lat, e.lat);
        if (e.lat > 1) chk({tag, "_in_ready_busy"}, busy_bad, 0);
    endtask

    vec_t tbl[12];
    logic [3:0] ops[12];

    initial begin
        exp_t act, e;
        logic busy_bad;

        tbl[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h1,  '{32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1}};
        tbl[1]  = '{4'b0110, 32'd5, 32'd5,         '{32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1}};
        tbl[2]  = '{4'b0111, 32'hFFFFFFFF, 32'h1,  '{32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1}};
        tbl[3]  = '{4'b0101, 32'hFFFFFFFF, 32'h1,  '{32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1}};
        tbl[4]  = '{4'b0011, 32'h1234, 32'h5678,   '{32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1}};
        tbl[5]  = '{4'b1000, 32'hFFFFFFFF, 32'h2,  '{32'hFFFFFFFE, 32'h1, 1'b0, 1'b0, 1'b0, 33}};
        tbl[6]  = '{4'b1010, 32'd100, 32'd7,       '{32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 33}};
        tbl[7]  = '{4'b1010, 32'd9, 32'd0,         '{32'hFFFFFFFF, 32'd9, 1'b0, 1'b0, 1'b1, 1}};
        tbl[8]  = '{4'b0000, 32'hF0F0, 32'hFF00,   '{32'hF000, 32'h0, 1'b0, 1'b0, 1'b0, 1}};
        tbl[9]  = '{4'b0001, 32'hF0F0, 32'hFF00,   '{32'hFFF0, 32'h0, 1'b0, 1'b0, 1'b0, 1}};
        tbl[10] = '{4'b0100, 32'h0, 32'h0,         '{32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1}};
        tbl[11] = '{4'b0110, 32'h80000000, 32'h1, '{32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1}};
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110,
                4'b0111, 4'b1000, 4'b1010, 4'b0011, 4'b1111, 4'b1010};

        #1 rst_n = 1'b0;
        #2;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", ULA_result, 0);
        chk("reset_hi", ULA_result_hi, 0);
        chk("reset_flags", {Zero, Overflow, Div_zero}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, act, busy_bad);
            compare($sformatf("vec%0d", i), act, tbl[i].e, busy_bad);
        end

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = ops[$urandom_range(0, 11)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 20);
            if ($urandom_range(0, 7) == 0) a = b;
            e = model(op, a, b);
            run_op(op, a, b, act, busy_bad);
            compare($sformatf("rnd%0d_op%0h", i, op), act, e, busy_bad);
        end

        // Backpressure: result held while a new request waits at the input
        @(negedge clk);
        ULA_control = 4'b0010; entrada_01 = 32'd1; entrada_02 = 32'd2; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        entrada_01 = 32'd10; entrada_02 = 32'd20;
        chk("bp_out_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_valid%0d", k), out_valid, 1);
            chk($sformatf("bp_hold_result%0d", k), ULA_result, 3);
            chk($sformatf("bp_hold_in_ready%0d", k), in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_consumed_valid", out_valid, 0);
        chk("bp_consumed_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_result", ULA_result, 30);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Asynchronous reset during a MULU discards the operation and the held result
        @(negedge clk);
        ULA_control = 4'b1000; entrada_01 = 32'hFFFFFFFF; entrada_02 = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_mulu_result_held", ULA_result, 30);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_result", ULA_result, 0);
        chk("rst_mid_hi", ULA_result_hi, 0);
        chk("rst_mid_flags", {Zero, Overflow, Div_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'b0010, 32'd3, 32'd4, act, busy_bad);
        compare("post_reset_add", act, '{32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1}, busy_bad);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
